// File: rtl/tlul_host_arb_ot.sv
// Round-robin A-channel arbiter for the host side of an M:1 TL-UL socket.
// It caps in-flight requests per host and retires them on D-channel handshakes.
module tlul_host_arb_ot #(
    parameter  int N      = 4,
    parameter  int MaxOut = 4,
    localparam int IdxW   = $clog2(N),
    localparam int CntW   = $clog2(MaxOut + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_i,
    output logic [N-1:0]      gnt_o,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o,
    input  logic              ready_i,
    input  logic              rsp_valid_i,
    input  logic              rsp_ready_i,
    input  logic [IdxW-1:0]   rsp_idx_i,
    output logic [N*CntW-1:0] outstanding_o,
    output logic [N-1:0]      full_o,
    output logic              err_o,
    output logic              lock_state_o
);

    // Handshakes: a beat transfers on a cycle where valid and ready are both
    // high; once valid is raised toward the device, the selected host stays
    // fixed until that beat transfers or the host withdraws its request.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } lock_state_e;

    lock_state_e     state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lidx_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] sel_idx;
    logic [CntW-1:0] cnt_q [N];
    logic [CntW-1:0] cnt_d [N];
    logic [N-1:0]    elig;
    logic [N-1:0]    inc_v, dec_v;
    logic            acc, ret, rsp_legal, underflow, err_q, err_d;

    assign lock_state_o = state_q;
    assign err_o        = err_q;

    // Only a non-power-of-two host count can produce an out-of-range source.
    if ((1 << IdxW) == N) begin : g_rsp_pow2
        assign rsp_legal = 1'b1;
    end else begin : g_rsp_range
        assign rsp_legal = (rsp_idx_i < IdxW'(N));
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = req_i[i] && (cnt_q[i] < CntW'(MaxOut));
        end
    end

    // First eligible host scanning upward from ptr, wrapping mod N.
    always_comb begin
        logic            found;
        logic [IdxW-1:0] jj;
        int              j;
        sel_idx = ptr_q;
        found   = 1'b0;
        jj      = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j  = (int'(ptr_q) + k) % N;
            jj = IdxW'(j);
            if (!found && elig[jj]) begin
                sel_idx = jj;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        valid_o = 1'b0;
        idx_o   = idx_q;
        state_d = state_q;
        if (state_q == ST_HOLD) begin
            idx_o   = lidx_q;
            valid_o = req_i[lidx_q];
        end else if (|elig) begin
            idx_o   = sel_idx;
            valid_o = 1'b1;
        end

        acc = valid_o && ready_i;
        case (state_q)
            ST_IDLE: if (valid_o && !ready_i) state_d = ST_HOLD;
            ST_HOLD: if (ready_i || !req_i[lidx_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ptr_d = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = acc && (idx_o == IdxW'(i));
        end
    end

    assign ret = rsp_valid_i && rsp_ready_i;

    // A same-host accept and retire cancel; a lone retire at zero is an error.
    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc_v[i] = acc && (idx_o == IdxW'(i));
            dec_v[i] = ret && rsp_legal && (rsp_idx_i == IdxW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CntW'(1);
                end
            end
        end
        err_d = underflow || (ret && !rsp_legal);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            outstanding_o[i*CntW +: CntW] = cnt_q[i];
            full_o[i]                     = (cnt_q[i] == CntW'(MaxOut));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lidx_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_o;
            err_q   <= err_d;
            if (state_q == ST_IDLE && valid_o && !ready_i) begin
                lidx_q <= idx_o;
            end
            if (acc) begin
                ptr_q <= ptr_d;
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tlul_host_arb_ot.sv
// Directed bench for tlul_host_arb_ot: two instances (MaxOut=2 and MaxOut=1)
// with a grant scoreboard per instance plus immediate-assertion checks.
module tb_tlul_host_arb_ot;

  localparam int N = 4;
  localparam int IdxW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] req1 = '0;
  logic ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic [IdxW-1:0] rsp_idx = '0;

  logic [N-1:0] gnt, gnt1;
  logic valid, valid1;
  logic [IdxW-1:0] idx, idx1;
  logic [7:0] outstanding;
  logic [3:0] outstanding1;
  logic [N-1:0] full, full1;
  logic err, err1;
  logic lock_state, lock_state1;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp1_q[$];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlul_host_arb_ot #(.N(4), .MaxOut(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .valid_o(valid),
    .idx_o(idx), .ready_i(ready), .rsp_valid_i(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_idx_i(rsp_idx),
    .outstanding_o(outstanding), .full_o(full), .err_o(err),
    .lock_state_o(lock_state)
  );

  tlul_host_arb_ot #(.N(4), .MaxOut(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .valid_o(valid1),
    .idx_o(idx1), .ready_i(ready), .rsp_valid_i(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_idx_i(rsp_idx),
    .outstanding_o(outstanding1), .full_o(full1), .err_o(err1),
    .lock_state_o(lock_state1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Before each edge, any grant on either instance must match its scoreboard.
  task automatic tick();
    if (gnt != '0) begin
      if (exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else chk("gnt_sb", 32'(gnt), 32'(exp_q.pop_front()));
    end
    if (gnt1 != '0) begin
      if (exp1_q.size() == 0) chk("gnt1_unexpected", 32'(gnt1), 32'd0);
      else chk("gnt1_sb", 32'(gnt1), 32'(exp1_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req1 = '0;
    ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic retire(input logic [IdxW-1:0] i);
    rsp_valid = 1'b1;
    rsp_ready = 1'b1;
    rsp_idx = i;
  endtask

  task automatic no_retire();
    rsp_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);

    // Round robin across all four hosts, MaxOut=1.
    req1 = 4'b1111;
    ready = 1'b1;
    exp1_q.push_back(4'b0001);
    exp1_q.push_back(4'b0010);
    exp1_q.push_back(4'b0100);
    exp1_q.push_back(4'b1000);
    #1;
    chk("rr_gnt0", 32'(gnt1), 32'b0001);
    tick();
    chk("rr_gnt1", 32'(gnt1), 32'b0010);
    tick();
    chk("rr_gnt2", 32'(gnt1), 32'b0100);
    tick();
    chk("rr_gnt3", 32'(gnt1), 32'b1000);
    tick();
    chk("rr_gnt_done", 32'(gnt1), 32'd0);
    chk("rr_valid_done", 32'(valid1), 32'd0);
    chk("rr_full", 32'(full1), 32'b1111);
    chk("rr_outstanding", 32'(outstanding1), 32'b1111);

    // Stall holds the selection; a new request does not re-arbitrate.
    do_reset();
    req = 4'b0011;
    ready = 1'b0;
    #1;
    chk("hold_idx_c0", 32'(idx), 32'd0);
    chk("hold_valid_c0", 32'(valid), 32'd1);
    chk("hold_gnt_c0", 32'(gnt), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("hold_idx", 32'(idx), 32'd0);
      chk("hold_valid", 32'(valid), 32'd1);
    end
    chk("hold_state", 32'(lock_state), 32'd1);
    req = 4'b1011;
    #1;
    chk("hold_idx_newreq", 32'(idx), 32'd0);
    ready = 1'b1;
    exp_q.push_back(4'b0001);
    #1;
    chk("hold_release_gnt", 32'(gnt), 32'b0001);
    tick();
    exp_q.push_back(4'b0010);
    chk("hold_next_idx", 32'(idx), 32'd1);
    chk("hold_next_gnt", 32'(gnt), 32'b0010);
    tick();
    req = '0;
    ready = 1'b0;
    #1;
    chk("hold_outstanding", 32'(outstanding), 32'h05);

    // Host at its limit is masked until a retire frees a slot.
    do_reset();
    req = 4'b0100;
    ready = 1'b1;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    #1;
    chk("lim_gnt_a", 32'(gnt), 32'b0100);
    tick();
    chk("lim_gnt_b", 32'(gnt), 32'b0100);
    tick();
    chk("lim_valid_masked", 32'(valid), 32'd0);
    chk("lim_full", 32'(full), 32'b0100);
    retire(2'd2);
    #1;
    chk("lim_valid_before_ret", 32'(valid), 32'd0);
    tick();
    no_retire();
    exp_q.push_back(4'b0100);
    #1;
    chk("lim_resume_valid", 32'(valid), 32'd1);
    chk("lim_resume_gnt", 32'(gnt), 32'b0100);
    tick();
    req = '0;
    #1;
    chk("lim_full_again", 32'(full), 32'b0100);

    // Simultaneous accept and retire.
    do_reset();
    req = 4'b0010;
    ready = 1'b1;
    exp_q.push_back(4'b0010);
    #1;
    tick();
    exp_q.push_back(4'b0010);
    retire(2'd1);
    #1;
    chk("same_gnt", 32'(gnt), 32'b0010);
    tick();
    no_retire();
    chk("same_outstanding", 32'(outstanding), 32'h04);
    chk("same_err", 32'(err), 32'd0);
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    #1;
    tick();
    chk("diff_pre_outstanding", 32'(outstanding), 32'h44);
    req = 4'b0001;
    retire(2'd3);
    exp_q.push_back(4'b0001);
    #1;
    chk("diff_gnt", 32'(gnt), 32'b0001);
    tick();
    no_retire();
    req = '0;
    #1;
    chk("diff_outstanding", 32'(outstanding), 32'h05);
    chk("diff_err", 32'(err), 32'd0);

    // Underflow reports one error pulse and leaves the count at zero.
    do_reset();
    retire(2'd0);
    #1;
    tick();
    no_retire();
    #1;
    chk("uf_err_pulse", 32'(err), 32'd1);
    chk("uf_outstanding", 32'(outstanding), 32'd0);
    tick();
    chk("uf_err_clear", 32'(err), 32'd0);

    // Reset while stalled discards all in-flight state.
    do_reset();
    ready = 1'b1;
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    #1;
    tick();
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    #1;
    tick();
    tick();
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    #1;
    tick();
    chk("mid_outstanding", 32'(outstanding), 32'h49);
    req = 4'b0001;
    ready = 1'b0;
    #1;
    tick();
    chk("mid_hold_state", 32'(lock_state), 32'd1);
    do_reset();
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_state", 32'(lock_state), 32'd0);
    req = 4'b1111;
    ready = 1'b1;
    exp_q.push_back(4'b0001);
    #1;
    chk("mid_restart_idx0", 32'(idx), 32'd0);
    tick();
    exp_q.push_back(4'b0010);
    chk("mid_restart_idx1", 32'(idx), 32'd1);
    tick();
    req = '0;
    ready = 1'b0;
    #1;

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("exp1_q_drained", 32'(exp1_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
